// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA sequencer: FF46 write copies XFER_LEN bytes into OAM.
// Optional CPU bus blocking during transfers is enabled by defining OAM_DMA_CPU_BLOCK_EN.
module oam_dma_controller #(
  parameter int XFER_LEN     = 160,
  parameter int CYC_PER_BYTE = 4,
  parameter int START_DELAY  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr_en,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  dma_reg,
  output logic        src_rd_en,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic        oam_wr_en,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        active,
  output logic        cpu_block
);

  localparam int PH_W = $clog2(CYC_PER_BYTE);
  localparam int DC_W = $clog2(START_DELAY + 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CYC_PER_BYTE - 1);
  localparam logic [DC_W-1:0] DLY_LAST = DC_W'(START_DELAY - 1);
  localparam logic [7:0]      IDX_LAST = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t            state, state_nxt;
  logic [7:0]        src_hi;
  logic [7:0]        idx;
  logic [PH_W-1:0]   phase;
  logic [DC_W-1:0]   dly_cnt;
  logic [7:0]        data_q;
  logic              trigger;

  assign trigger = reg_wr_en && (reg_addr == 16'hFF46);
  assign active  = (state != IDLE);

`ifdef OAM_DMA_CPU_BLOCK_EN
  assign cpu_block = active && !((reg_addr >= 16'hFF80) && (reg_addr <= 16'hFFFE));
`else
  assign cpu_block = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dma_reg <= 8'hFF;
      src_hi  <= 8'h00;
      idx     <= 8'h00;
      phase   <= '0;
      dly_cnt <= '0;
      data_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        // Echo RAM E000-FDFF mirrors C000-DDFF, so fold the high byte down.
        dma_reg <= reg_wdata;
        src_hi  <= (reg_wdata >= 8'hE0) ? (reg_wdata - 8'h20) : reg_wdata;
        idx     <= 8'h00;
        dly_cnt <= '0;
        phase   <= '0;
      end else begin
        case (state)
          START: begin
            dly_cnt <= dly_cnt + DC_W'(1);
            phase   <= '0;
          end
          XFER: begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            if (phase == '0)
              data_q <= src_rdata;
            if ((phase == PH_LAST) && (idx != IDX_LAST))
              idx <= idx + 8'h01;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    src_rd_en = 1'b0;
    src_addr  = 16'h0000;
    oam_wr_en = 1'b0;
    oam_addr  = 8'h00;
    oam_wdata = 8'h00;
    case (state)
      IDLE: ;
      START: begin
        if (dly_cnt == DLY_LAST)
          state_nxt = XFER;
      end
      XFER: begin
        if (phase == '0) begin
          src_rd_en = 1'b1;
          src_addr  = {src_hi, idx};
        end
        if (phase == PH_W'(1)) begin
          oam_wr_en = 1'b1;
          oam_addr  = idx;
          oam_wdata = data_q;
        end
        if ((phase == PH_LAST) && (idx == IDX_LAST))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new trigger always restarts, even on the cycle the last byte finishes.
    if (trigger)
      state_nxt = START;
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - directed self-checking bench for oam_dma_controller.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_wr_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  dma_reg;
  logic        src_rd_en;
  logic [15:0] src_addr;
  logic [7:0]  src_rdata;
  logic        oam_wr_en;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        active;
  logic        cpu_block;

  int errors = 0;
  int checks = 0;

`ifdef OAM_DMA_CPU_BLOCK_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  // Source memory model: returns the low address byte.
  assign src_rdata = src_addr[7:0];

  oam_dma_controller dut (
    .clk       (clk),
    .reset     (reset),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .dma_reg   (dma_reg),
    .src_rd_en (src_rd_en),
    .src_addr  (src_addr),
    .src_rdata (src_rdata),
    .oam_wr_en (oam_wr_en),
    .oam_addr  (oam_addr),
    .oam_wdata (oam_wdata),
    .active    (active),
    .cpu_block (cpu_block)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = v;
    step();
    reg_wr_en = 1'b0;
    reg_addr  = 16'h0000;
    reg_wdata = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dma_reg !== 8'hFF) begin errors++; $display("FAIL reset_dma_reg: got %0h expected ff", dma_reg); end
    checks++;
    if ({active, src_rd_en, oam_wr_en, cpu_block} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {active, src_rd_en, oam_wr_en, cpu_block});
    end
    checks++;
    if ({src_addr, oam_addr, oam_wdata} !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got %0h expected 0", {src_addr, oam_addr, oam_wdata});
    end
  endtask

  task automatic test_full_transfer();
    int nwr = 0, bad = 0, first_src = -1, last_wr = -1, fall = -1;
    logic [15:0] first_addr = 16'h0;
    bus_write(16'hFF46, 8'hC1);
    for (int t = 1; t <= 700; t++) begin
      if (src_rd_en && first_src < 0) begin first_src = t; first_addr = src_addr; end
      if (oam_wr_en) begin
        if (oam_addr !== nwr[7:0] || oam_wdata !== nwr[7:0]) bad++;
        nwr++;
        last_wr = t;
      end
      if (!active) begin fall = t; break; end
      step();
    end
    checks++;
    if (dma_reg !== 8'hC1) begin errors++; $display("FAIL full_dma_reg: got %0h expected c1", dma_reg); end
    checks++;
    if (first_src !== 5) begin errors++; $display("FAIL full_first_src_cycle: got %0d expected 5", first_src); end
    checks++;
    if (first_addr !== 16'hC100) begin errors++; $display("FAIL full_first_src_addr: got %0h expected c100", first_addr); end
    checks++;
    if (nwr !== 160) begin errors++; $display("FAIL full_write_count: got %0d expected 160", nwr); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_write_data: got %0d bad writes expected 0", bad); end
    checks++;
    if (last_wr !== 642) begin errors++; $display("FAIL full_last_write_cycle: got %0d expected 642", last_wr); end
    checks++;
    if (fall !== 645) begin errors++; $display("FAIL full_active_fall_cycle: got %0d expected 645", fall); end
  endtask

  task automatic test_echo_source();
    logic seen = 1'b0;
    logic [15:0] a = 16'h0;
    bus_write(16'hFF46, 8'hE3);
    checks++;
    if (dma_reg !== 8'hE3) begin errors++; $display("FAIL echo_dma_reg: got %0h expected e3", dma_reg); end
    for (int t = 0; t < 10 && !seen; t++) begin
      if (src_rd_en) begin seen = 1'b1; a = src_addr; end
      else step();
    end
    checks++;
    if (!seen || a !== 16'hC300) begin errors++; $display("FAIL echo_src_addr: got %0h seen=%0b expected c300", a, seen); end
    do_reset();
  endtask

  task automatic test_restart();
    logic found = 1'b0;
    int nwr = 0, bad = 0, gap = 0;
    logic first = 1'b0;
    logic [15:0] a = 16'h0;
    bus_write(16'hFF46, 8'hC0);
    for (int t = 0; t < 400 && !found; t++) begin
      if (oam_wr_en && oam_addr == 8'd50) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL restart_reach_idx50: got timeout expected write to 50"); end
    bus_write(16'hFF46, 8'hD0);
    checks++;
    if ({active, src_rd_en, oam_wr_en} !== 3'b100) begin
      errors++; $display("FAIL restart_next_clock: got %b expected 100", {active, src_rd_en, oam_wr_en});
    end
    for (int t = 0; t < 700 && nwr < 160; t++) begin
      if (!active) gap++;
      if (src_rd_en && !first) begin first = 1'b1; a = src_addr; end
      if (oam_wr_en) begin
        if (oam_addr !== nwr[7:0] || oam_wdata !== nwr[7:0]) bad++;
        nwr++;
      end
      step();
    end
    checks++;
    if (gap !== 0) begin errors++; $display("FAIL restart_active_gap: got %0d low cycles expected 0", gap); end
    checks++;
    if (a !== 16'hD000) begin errors++; $display("FAIL restart_src_addr: got %0h expected d000", a); end
    checks++;
    if (nwr !== 160 || bad !== 0) begin errors++; $display("FAIL restart_writes: got %0d writes %0d bad expected 160/0", nwr, bad); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic found = 1'b0;
    bus_write(16'hFF46, 8'hC1);
    for (int t = 0; t < 700 && !found; t++) begin
      if (oam_wr_en && oam_addr == 8'd159) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_reach_last: got timeout expected write to 159"); end
    step();
    step();
    bus_write(16'hFF46, 8'hC2);
    checks++;
    if ({active, src_rd_en, oam_wr_en} !== 3'b100) begin
      errors++; $display("FAIL b2b_no_idle: got %b expected 100", {active, src_rd_en, oam_wr_en});
    end
    repeat (4) step();
    checks++;
    if (src_rd_en !== 1'b1 || src_addr !== 16'hC200) begin
      errors++; $display("FAIL b2b_first_read: got en=%b addr=%0h expected 1/c200", src_rd_en, src_addr);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    int strobes = 0;
    bus_write(16'hFF46, 8'hC1);
    for (int t = 0; t < 400 && !found; t++) begin
      if (oam_wr_en && oam_addr == 8'd80) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach_idx80: got timeout expected write to 80"); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({active, src_rd_en, oam_wr_en} !== 3'b000 || dma_reg !== 8'hFF) begin
      errors++; $display("FAIL rstmid_abort: got flags=%b dma_reg=%0h expected 000/ff", {active, src_rd_en, oam_wr_en}, dma_reg);
    end
    for (int t = 0; t < 200; t++) begin
      if (oam_wr_en || src_rd_en) strobes++;
      step();
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL rstmid_no_writes: got %0d strobes expected 0", strobes); end
  endtask

  task automatic test_other_addr();
    int busy = 0;
    bus_write(16'hFF47, 8'h12);
    bus_write(16'hFF45, 8'h34);
    for (int t = 0; t < 20; t++) begin
      if (active || src_rd_en || oam_wr_en) busy++;
      step();
    end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL other_addr_idle: got %0d busy cycles expected 0", busy); end
    checks++;
    if (dma_reg !== 8'hFF) begin errors++; $display("FAIL other_addr_dma_reg: got %0h expected ff", dma_reg); end
  endtask

  task automatic test_cpu_block();
    logic [15:0] addrs [4] = '{16'hC000, 16'hFF90, 16'hFF80, 16'hFFFF};
    logic        blk   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    reg_addr = 16'hC000;
    #1;
    checks++;
    if (cpu_block !== 1'b0) begin errors++; $display("FAIL cpu_block_idle: got %b expected 0", cpu_block); end
    bus_write(16'hFF46, 8'hC1);
    step();
    for (int i = 0; i < 4; i++) begin
      reg_addr = addrs[i];
      #1;
      checks++;
      if (cpu_block !== (BLK_EN & blk[i])) begin
        errors++; $display("FAIL cpu_block_%0h: got %b expected %b", addrs[i], cpu_block, BLK_EN & blk[i]);
      end
    end
    reg_addr = 16'h0000;
    do_reset();
  endtask

  initial begin
    reset     = 1'b1;
    reg_wr_en = 1'b0;
    reg_addr  = 16'h0000;
    reg_wdata = 8'h00;
    test_reset();
    test_full_transfer();
    test_echo_source();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_other_addr();
    test_cpu_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
